// File: rtl/wb_sdr_traffic_gen.sv
// Wishbone burst traffic generator for SDRAM bring-up: writes a selectable
// data pattern over a region in incrementing bursts, then reads the region
// back and counts mismatches, recording the address of the first one.
module wb_sdr_traffic_gen #(
    parameter int APP_AW    = 26,
    parameter int DW        = 32,
    parameter int BW        = 4,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start,
    input  logic [APP_AW-1:0] base_addr,
    input  logic [15:0]       num_words,
    input  logic [1:0]        pattern_sel,
    input  logic              sdr_init_done,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       err_cnt,
    output logic [APP_AW-1:0] first_err_addr,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [BW-1:0]     wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [31:0]       LFSR_SEED  = 32'hACE1_0001;
    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0]       LFSR_TAPS  = 32'h8020_0003;
    localparam logic [APP_AW-1:0] ALIGN_MASK = ~APP_AW'(BW - 1);
    localparam logic [2:0]        CTI_INCR   = 3'b010;
    localparam logic [2:0]        CTI_EOB    = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_WR_BURST,
        S_WR_GAP,
        S_RD_BURST,
        S_RD_GAP,
        S_DONE
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [DW-1:0] pattern(input logic [15:0] idx,
                                              input logic [31:0] lf,
                                              input logic [1:0]  sel);
        logic [DW-1:0] idx_ext;
        idx_ext = DW'(idx);
        case (sel)
            2'd0:    return idx_ext;
            2'd1:    return lf[DW-1:0];
            2'd2:    return DW'(1'b1) << (idx % DW);
            default: return ~idx_ext;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [4:0] burst_len(input logic [15:0] rem);
        return (rem >= 16'(BURST_LEN)) ? 5'(BURST_LEN) : rem[4:0];
    endfunction

    state_t            state_q, state_n;
    logic [APP_AW-1:0] base_q, base_n;
    logic [15:0]       num_q, num_n;
    logic [1:0]        psel_q, psel_n;
    logic [APP_AW-1:0] addr_q, addr_n;
    logic [15:0]       widx_q, widx_n;
    logic [15:0]       rem_q, rem_n;
    logic [4:0]        beats_q, beats_n;
    logic [31:0]       lfsr_q, lfsr_n;
    logic [TW-1:0]     to_q, to_n;
    logic              cyc_q, cyc_n;
    logic              stb_q, stb_n;
    logic              we_q, we_n;
    logic [2:0]        cti_q, cti_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              timeout_q, timeout_n;
    logic [15:0]       err_q, err_n;
    logic [APP_AW-1:0] ferr_q, ferr_n;
    logic              launch, launch_we;
    logic [15:0]       launch_rem;
    logic [DW-1:0]     pat_cur;

    assign pat_cur = pattern(widx_q, lfsr_q, psel_q);

    // Next-state, bus control and result logic for the write/verify sequencer
    always_comb begin
        state_n    = state_q;
        base_n     = base_q;
        num_n      = num_q;
        psel_n     = psel_q;
        addr_n     = addr_q;
        widx_n     = widx_q;
        rem_n      = rem_q;
        beats_n    = beats_q;
        lfsr_n     = lfsr_q;
        to_n       = to_q;
        cyc_n      = cyc_q;
        stb_n      = stb_q;
        we_n       = we_q;
        cti_n      = cti_q;
        busy_n     = busy_q;
        done_n     = done_q;
        timeout_n  = timeout_q;
        err_n      = err_q;
        ferr_n     = ferr_q;
        launch     = 1'b0;
        launch_we  = 1'b0;
        launch_rem = rem_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_n    = base_addr & ALIGN_MASK;
                    num_n     = num_words;
                    psel_n    = pattern_sel;
                    addr_n    = base_addr & ALIGN_MASK;
                    widx_n    = 16'd0;
                    rem_n     = num_words;
                    lfsr_n    = LFSR_SEED;
                    busy_n    = 1'b1;
                    done_n    = 1'b0;
                    timeout_n = 1'b0;
                    err_n     = 16'd0;
                    ferr_n    = '0;
                    state_n   = (num_words == 16'd0) ? S_DONE : S_WAIT_INIT;
                end
            end
            S_WAIT_INIT: begin
                if (sdr_init_done) begin
                    launch     = 1'b1;
                    launch_we  = 1'b1;
                    launch_rem = rem_q;
                    state_n    = S_WR_BURST;
                end
            end
            S_WR_BURST, S_RD_BURST: begin
                if (stb_q && wb_ack_i) begin
                    if (state_q == S_RD_BURST && wb_dat_i != pat_cur) begin
                        if (err_q == 16'd0) begin
                            ferr_n = addr_q;
                        end
                        err_n = sat_inc(err_q);
                    end
                    addr_n = addr_q + APP_AW'(BW);
                    widx_n = widx_q + 16'd1;
                    rem_n  = rem_q - 16'd1;
                    lfsr_n = lfsr_step(lfsr_q);
                    to_n   = '0;
                    if (beats_q == 5'd1) begin
                        cyc_n   = 1'b0;
                        stb_n   = 1'b0;
                        we_n    = 1'b0;
                        cti_n   = 3'b000;
                        state_n = (state_q == S_WR_BURST) ? S_WR_GAP : S_RD_GAP;
                    end else begin
                        beats_n = beats_q - 5'd1;
                        cti_n   = (beats_q == 5'd2) ? CTI_EOB : CTI_INCR;
                    end
                end else if (to_q == TW'(TIMEOUT)) begin
                    cyc_n     = 1'b0;
                    stb_n     = 1'b0;
                    we_n      = 1'b0;
                    cti_n     = 3'b000;
                    timeout_n = 1'b1;
                    state_n   = S_DONE;
                end else begin
                    to_n = to_q + TW'(1);
                end
            end
            S_WR_GAP: begin
                launch = 1'b1;
                if (rem_q == 16'd0) begin
                    // Write phase finished: rewind address and pattern for verify
                    addr_n     = base_q;
                    widx_n     = 16'd0;
                    rem_n      = num_q;
                    lfsr_n     = LFSR_SEED;
                    launch_we  = 1'b0;
                    launch_rem = num_q;
                    state_n    = S_RD_BURST;
                end else begin
                    launch_we  = 1'b1;
                    launch_rem = rem_q;
                    state_n    = S_WR_BURST;
                end
            end
            S_RD_GAP: begin
                if (rem_q == 16'd0) begin
                    state_n = S_DONE;
                end else begin
                    launch     = 1'b1;
                    launch_we  = 1'b0;
                    launch_rem = rem_q;
                    state_n    = S_RD_BURST;
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        if (launch) begin
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            we_n    = launch_we;
            beats_n = burst_len(launch_rem);
            cti_n   = (burst_len(launch_rem) == 5'd1) ? CTI_EOB : CTI_INCR;
            to_n    = '0;
        end
    end

    // State and output registers; reset clears everything, including a live burst
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            num_q     <= '0;
            psel_q    <= '0;
            addr_q    <= '0;
            widx_q    <= '0;
            rem_q     <= '0;
            beats_q   <= '0;
            lfsr_q    <= '0;
            to_q      <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            cti_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            ferr_q    <= '0;
        end else begin
            state_q   <= state_n;
            base_q    <= base_n;
            num_q     <= num_n;
            psel_q    <= psel_n;
            addr_q    <= addr_n;
            widx_q    <= widx_n;
            rem_q     <= rem_n;
            beats_q   <= beats_n;
            lfsr_q    <= lfsr_n;
            to_q      <= to_n;
            cyc_q     <= cyc_n;
            stb_q     <= stb_n;
            we_q      <= we_n;
            cti_q     <= cti_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            timeout_q <= timeout_n;
            err_q     <= err_n;
            ferr_q    <= ferr_n;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = stb_q;
    assign wb_we_o        = we_q;
    assign wb_addr_o      = addr_q;
    assign wb_dat_o       = (stb_q && we_q) ? pat_cur : '0;
    assign wb_sel_o       = {BW{stb_q}};
    assign wb_cti_o       = cti_q;

endmodule

// File: tb/tb_wb_sdr_traffic_gen.sv
// Directed bench for wb_sdr_traffic_gen with a memory-backed Wishbone slave
// and a scoreboard of expected bus beats.
module tb_wb_sdr_traffic_gen;

    localparam int APP_AW = 26;
    localparam int DW     = 32;
    localparam int BW     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [APP_AW-1:0] base_addr = '0;
    logic [15:0]       num_words = '0;
    logic [1:0]        pattern_sel = '0;
    logic              sdr_init_done = 1'b1;
    logic              busy, done, timeout;
    logic [15:0]       err_cnt;
    logic [APP_AW-1:0] first_err_addr;
    logic              wb_cyc_o, wb_stb_o, wb_we_o;
    logic [APP_AW-1:0] wb_addr_o;
    logic [DW-1:0]     wb_dat_o;
    logic [BW-1:0]     wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic              wb_ack_i;
    logic [DW-1:0]     wb_dat_i;

    always #5 clk = ~clk;

    wb_sdr_traffic_gen dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .pattern_sel(pattern_sel), .sdr_init_done(sdr_init_done),
        .busy(busy), .done(done), .timeout(timeout), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
    );

    typedef struct {
        logic [APP_AW-1:0] addr;
        logic              we;
        logic [31:0]       dat;
        logic [2:0]        cti;
    } beat_t;

    beat_t       sbq[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] mem [0:255];
    bit          ack_en = 1'b1;
    bit          sb_en = 1'b0;
    bit [31:0]   inj_mask = '0;
    int          rd_beat = 0;
    int          rd_base = 0;
    int          rd_rel;
    logic        inj;

    // Memory slave: zero-wait-state ack, optional bit-0 corruption on chosen read beats
    assign wb_ack_i = wb_stb_o & ack_en;
    always_comb begin
        rd_rel = rd_beat - rd_base + 1;
        inj = 1'b0;
        if (!wb_we_o && rd_rel >= 0 && rd_rel < 32) inj = inj_mask[rd_rel];
    end
    assign wb_dat_i = mem[wb_addr_o[9:2]] ^ {31'b0, inj};

    always @(posedge clk) begin
        if (wb_stb_o && wb_ack_i) begin
            if (wb_we_o) mem[wb_addr_o[9:2]] <= wb_dat_o;
            else         rd_beat <= rd_beat + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
        return t;
    endfunction

    function automatic logic [31:0] tb_pat(input int i, input logic [31:0] lf, input logic [1:0] sel);
        case (sel)
            2'd0:    return 32'(i);
            2'd1:    return lf;
            2'd2:    return 32'h1 << (i % 32);
            default: return ~(32'(i));
        endcase
    endfunction

    // Expected write beats followed by expected read beats
    task automatic push_op(input logic [APP_AW-1:0] base, input int n, input logic [1:0] sel);
        beat_t b;
        logic [31:0] lf;
        logic [APP_AW-1:0] a;
        for (int ph = 0; ph < 2; ph++) begin
            lf = 32'hACE1_0001;
            a  = base;
            for (int i = 0; i < n; i++) begin
                b.addr = a;
                b.we   = (ph == 0);
                b.dat  = tb_pat(i, lf, sel);
                b.cti  = ((i % 8) == 7 || i == n - 1) ? 3'b111 : 3'b010;
                sbq.push_back(b);
                a  = a + APP_AW'(4);
                lf = lfsr_nx(lf);
            end
        end
    endtask

    task automatic start_op(input logic [APP_AW-1:0] base, input int n, input logic [1:0] sel);
        @(negedge clk);
        rd_base     = rd_beat;
        base_addr   = base;
        num_words   = 16'(n);
        pattern_sel = sel;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
    endtask

    // Scoreboard monitor: pops one expected beat per acked cycle and checks burst gaps
    int gap_ph = 0;
    always @(negedge clk) begin
        beat_t b;
        if (!sb_en || rst) begin
            gap_ph = 0;
        end else begin
            if (gap_ph == 1) begin
                chk("gap_cyc_low", 64'(wb_cyc_o), 64'd0);
                gap_ph = (sbq.size() > 0) ? 2 : 0;
            end else if (gap_ph == 2) begin
                chk("gap_cyc_high", 64'(wb_cyc_o), 64'd1);
                gap_ph = 0;
            end
            if (wb_stb_o && wb_ack_i) begin
                if (sbq.size() == 0) begin
                    chk("beat_expected", 64'(sbq.size() != 0), 64'd1);
                end else begin
                    b = sbq.pop_front();
                    chk("beat_addr", 64'(wb_addr_o), 64'(b.addr));
                    chk("beat_we", 64'(wb_we_o), 64'(b.we));
                    chk("beat_cti", 64'(wb_cti_o), 64'(b.cti));
                    chk("beat_sel", 64'(wb_sel_o), 64'hF);
                    chk("beat_cyc", 64'(wb_cyc_o), 64'd1);
                    if (b.we) chk("beat_wdata", 64'(wb_dat_o), 64'(b.dat));
                end
                if (wb_cti_o == 3'b111) gap_ph = 1;
            end
        end
    end

    initial begin
        int k, cnt, acks;
        logic [APP_AW-1:0] a0, alast;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_first_err", 64'(first_err_addr), 64'd0);
        chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rst_stb", 64'(wb_stb_o), 64'd0);
        chk("rst_addr", 64'(wb_addr_o), 64'd0);
        chk("rst_dat", 64'(wb_dat_o), 64'd0);
        rst = 1'b0;
        sb_en = 1'b1;

        // Addr-index pattern, 8/8/4 bursts, held off until init completes
        sdr_init_done = 1'b0;
        push_op(26'h100, 20, 2'd0);
        start_op(26'h100, 20, 2'd0);
        repeat (4) @(negedge clk);
        chk("wait_init_cyc", 64'(wb_cyc_o), 64'd0);
        chk("wait_init_busy", 64'(busy), 64'd1);
        sdr_init_done = 1'b1;
        wait_done("addr_idx", 200);
        chk("addr_idx_err", 64'(err_cnt), 64'd0);
        chk("addr_idx_busy", 64'(busy), 64'd0);
        chk("addr_idx_timeout", 64'(timeout), 64'd0);
        chk("addr_idx_sb_empty", 64'(sbq.size()), 64'd0);

        // Walking-one across more than DW words, then inverted index with a 1-beat tail
        push_op(26'h200, 34, 2'd2);
        start_op(26'h200, 34, 2'd2);
        wait_done("walk1", 300);
        chk("walk1_err", 64'(err_cnt), 64'd0);
        push_op(26'h040, 9, 2'd3);
        start_op(26'h040, 9, 2'd3);
        wait_done("inv_idx", 200);
        chk("inv_idx_err", 64'(err_cnt), 64'd0);

        // LFSR with corrupted read beats 3 and 7
        inj_mask = (32'h1 << 3) | (32'h1 << 7);
        push_op(26'h0, 8, 2'd1);
        start_op(26'h0, 8, 2'd1);
        wait_done("lfsr_inj", 200);
        chk("lfsr_inj_err_cnt", 64'(err_cnt), 64'd2);
        chk("lfsr_inj_first_addr", 64'(first_err_addr), 64'h8);
        inj_mask = '0;

        // Reset on the fifth write beat
        sb_en = 1'b0;
        start_op(26'h0, 20, 2'd0);
        acks = 0;
        k = 0;
        while (acks < 5 && k < 100) begin
            @(negedge clk);
            k++;
            if (wb_stb_o && wb_ack_i) acks++;
        end
        chk("rst_mid_reached_beat5", 64'(acks), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rst_mid_stb", 64'(wb_stb_o), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        sbq.delete();
        sb_en = 1'b1;

        // Address wrap at the top of the space, also the restart after reset
        push_op(26'h3FF_FFF8, 4, 2'd0);
        start_op(26'h3FF_FFF8, 4, 2'd0);
        wait_done("wrap", 100);
        chk("wrap_err", 64'(err_cnt), 64'd0);
        chk("wrap_sb_empty", 64'(sbq.size()), 64'd0);

        // Zero-length request: done two cycles after start, no bus activity
        @(negedge clk);
        num_words = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_done_early", 64'(done), 64'd0);
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_cyc0", 64'(wb_cyc_o), 64'd0);
        @(negedge clk);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy_clr", 64'(busy), 64'd0);
        chk("zero_cyc1", 64'(wb_cyc_o), 64'd0);

        // Single word: one-beat bursts carry end-of-burst
        push_op(26'h080, 1, 2'd3);
        start_op(26'h080, 1, 2'd3);
        wait_done("single", 50);
        chk("single_err", 64'(err_cnt), 64'd0);

        // Stalled slave: stb must fall 1024 cycles after it rose
        ack_en = 1'b0;
        start_op(26'h010, 4, 2'd0);
        k = 0;
        while (!wb_stb_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        a0 = wb_addr_o;
        alast = a0;
        cnt = 0;
        while (wb_stb_o && cnt < 1100) begin
            alast = wb_addr_o;
            @(negedge clk);
            cnt++;
        end
        chk("stall_stb_cycles", 64'(cnt), 64'd1024);
        chk("stall_addr_stable", 64'(alast), 64'(a0));
        wait_done("stall", 20);
        chk("stall_timeout", 64'(timeout), 64'd1);
        chk("stall_busy", 64'(busy), 64'd0);
        ack_en = 1'b1;

        // Next start clears the abort flag
        push_op(26'h000, 2, 2'd0);
        start_op(26'h000, 2, 2'd0);
        wait_done("post_stall", 50);
        chk("post_stall_timeout", 64'(timeout), 64'd0);
        chk("post_stall_err", 64'(err_cnt), 64'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sdr_traffic_gen.md
Name: wb_sdr_traffic_gen

Overview:
Wishbone master that sits directly upstream of sdrc_top. It drives the controller's wb_* slave port with incrementing bursts: first it writes a programmable pattern, then it reads the same region back and compares. It reports a mismatch count and the first failing address. It serves as the on-chip stimulus/BIST source for SDRAM bring-up.

Parameters:
APP_AW, 26, Wishbone byte-address width
DW, 32, Wishbone data width
BW, 4, byte-select width (DW/8)
BURST_LEN, 8, maximum beats per Wishbone burst (1..16)
TIMEOUT, 1023, cycles without ack while stb high before abort

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous reset, active-high
start  in  1  one-cycle request, sampled in IDLE only
base_addr  in  APP_AW  start byte address, BW-aligned
num_words  in  16  words to write then verify
pattern_sel  in  2  0=addr-index, 1=LFSR, 2=walking-one, 3=~addr-index
sdr_init_done  in  1  controller init complete
busy  out  1  operation in progress
done  out  1  operation finished, held until next accepted start
timeout  out  1  abort flag, valid with done
err_cnt  out  16  saturating mismatch count
first_err_addr  out  APP_AW  address of first mismatch
wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone controls
wb_addr_o  out  APP_AW  byte address
wb_dat_o  out  DW  write data
wb_sel_o  out  BW  always all-ones while stb high
wb_cti_o  out  3  010 incrementing, 111 end-of-burst
wb_ack_i  in  1  slave acknowledge
wb_dat_i  in  DW  read data

Behaviour:
- Reset, and on any wb_rst_i, in the next cycle: every output is 0, state=IDLE, all counters are cleared. A reset mid-burst drops cyc/stb with no handshake completion.
- States: IDLE -> WAIT_INIT -> WR_BURST <-> WR_GAP -> RD_BURST <-> RD_GAP -> DONE -> IDLE.
- IDLE: on start, latch base_addr, num_words and pattern_sel; set busy=1; clear done, timeout, err_cnt and first_err_addr. If num_words=0, go directly to DONE with no bus activity.
- WAIT_INIT: wait until sdr_init_done=1.
- Burst length = min(BURST_LEN, remaining words).
- Within a burst, cyc and stb stay high continuously. wb_cti_o=010 on every beat except the last, which is 111; a 1-beat burst uses 111.
- A beat completes on a cycle with stb=1 and ack=1. On that edge, addr advances by BW, the word index increments, and the pattern generator steps. Addr wraps modulo 2^APP_AW.
- After the last ack of a burst, cyc and stb are low for exactly one cycle (GAP state), then the next burst starts.
- After the final write burst, the next burst is a read. The pattern generator and address reload from the latched values.
- Pattern for word i at byte address a:
  - 0: data = i, zero-extended.
  - 3: data = ~i.
  - 2: data = 1 << (i mod DW).
  - 1: 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1, seed 32'hACE1_0001, stepped once per beat; for DW<32 use the low DW bits.
- Read compare on each ack: a full-width compare of wb_dat_i against expected. On mismatch, err_cnt increments and saturates at 16'hFFFF. first_err_addr is captured only on the first mismatch.
- Timeout: a counter clears on each ack and on stb rise, and increments while stb=1 and ack=0. When it reaches TIMEOUT: drop cyc/stb in the next cycle, set timeout=1, go to DONE.
- DONE: busy=0 and done=1; return to IDLE in the same cycle. done, timeout and err_cnt are held until the next accepted start.
- start while busy is ignored.
- ack while stb=0 is ignored.
- wb_we_o=1 throughout write bursts and 0 throughout read bursts.
- Addr and data are stable while stb=1 and ack=0.

Test Plan:
- Reset mid-operation: assert wb_rst_i at beat 5 of a write burst -> next cycle cyc=stb=busy=0 and err_cnt=0; a new start then runs normally.
- Addr-index pattern: base=0x100, num_words=20, BURST_LEN=8, 32-bit SDRAM model. Required response: write bursts of 8/8/4 with a one-cycle cyc gap between bursts, then read bursts of 8/8/4. cti=111 on beats 8, 16 and 20. Finish with done=1 and err_cnt=0.
- Mismatch injection: force wb_dat_i bit 0 inverted on read beats 3 and 7 (base=0x0, LFSR pattern) -> err_cnt=2, first_err_addr=0x8.
- num_words=0 -> done rises two cycles after start with no cyc assertion; num_words=1 -> a single-beat burst with cti=111.
- Stall slave: ack never returned, TIMEOUT=1023 -> stb falls 1024 cycles after it rose; timeout=1, done=1.
- Wrap-around: base=2^26-8, num_words=4 -> addresses 0x3FFFFF8, 0x3FFFFFC, 0x0, 0x4.
